// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result inputs from the three execution units and the two CDB broadcast ports
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif
interface cdb_arbiter_if #(
    parameter int PRF_SIZE = `PRF_SIZE,
    parameter int ROB_SIZE = `ROB_SIZE
);
    localparam int TW = $clog2(PRF_SIZE);
    localparam int RW = $clog2(ROB_SIZE);
    logic          adder_result_valid;
    logic [63:0]   adder_result;
    logic [TW-1:0] adder_dest_tag;
    logic [RW-1:0] adder_rob_idx;
    logic          mult_result_valid;
    logic [63:0]   mult_result;
    logic [TW-1:0] mult_dest_tag;
    logic [RW-1:0] mult_rob_idx;
    logic          memory_result_valid;
    logic [63:0]   memory_result;
    logic [TW-1:0] memory_dest_tag;
    logic [RW-1:0] memory_rob_idx;
    logic          adder_available;
    logic          mult_available;
    logic          memory_available;
    logic          cdb1_valid;
    logic [TW-1:0] cdb1_tag;
    logic [63:0]   cdb1_value;
    logic [RW-1:0] cdb1_rob_idx;
    logic          cdb2_valid;
    logic [TW-1:0] cdb2_tag;
    logic [63:0]   cdb2_value;
    logic [RW-1:0] cdb2_rob_idx;
    logic          overflow_err;
    modport slave (
        input  adder_result_valid, adder_result, adder_dest_tag, adder_rob_idx,
        input  mult_result_valid, mult_result, mult_dest_tag, mult_rob_idx,
        input  memory_result_valid, memory_result, memory_dest_tag, memory_rob_idx,
        output adder_available, mult_available, memory_available,
        output cdb1_valid, cdb1_tag, cdb1_value, cdb1_rob_idx,
        output cdb2_valid, cdb2_tag, cdb2_value, cdb2_rob_idx,
        output overflow_err
    );
    modport master (
        output adder_result_valid, adder_result, adder_dest_tag, adder_rob_idx,
        output mult_result_valid, mult_result, mult_dest_tag, mult_rob_idx,
        output memory_result_valid, memory_result, memory_dest_tag, memory_rob_idx,
        input  adder_available, mult_available, memory_available,
        input  cdb1_valid, cdb1_tag, cdb1_value, cdb1_rob_idx,
        input  cdb2_valid, cdb2_tag, cdb2_value, cdb2_rob_idx,
        input  overflow_err
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers results from adder/mult/memory and broadcasts up to two per cycle, round-robin
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif
module cdb_arbiter #(
    parameter int PRF_SIZE  = `PRF_SIZE,
    parameter int ROB_SIZE  = `ROB_SIZE,
    parameter int BUF_DEPTH = 2
) (
    input logic          i_clock,
    input logic          i_reset,
    cdb_arbiter_if.slave io_cdb
);
    localparam int TW = $clog2(PRF_SIZE);
    localparam int RW = $clog2(ROB_SIZE);
    localparam int EW = 64 + TW + RW;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [EW-1:0] r_mem [3][BUF_DEPTH];
    logic [CW-1:0] r_count [3];
    logic [1:0]    r_ptr;
    logic          r_overflow;

    logic [2:0]    w_in_valid;
    logic [EW-1:0] w_in_data [3];
    logic [2:0]    w_ne;
    logic [2:0]    w_full;
    logic [2:0]    w_enq;
    logic [2:0]    w_deq;
    logic          w_g1_valid;
    logic          w_g2_valid;
    logic [1:0]    w_g1;
    logic [1:0]    w_g2;
    logic [1:0]    w_last;
    logic          w_v1;
    logic          w_v2;

    function automatic logic [1:0] rr(input logic [1:0] p, input int k);
        logic [2:0] t;
        t = {1'b0, p} + 3'(k);
        return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
    endfunction

    assign w_in_valid   = {io_cdb.memory_result_valid, io_cdb.mult_result_valid, io_cdb.adder_result_valid};
    assign w_in_data[0] = {io_cdb.adder_result, io_cdb.adder_dest_tag, io_cdb.adder_rob_idx};
    assign w_in_data[1] = {io_cdb.mult_result, io_cdb.mult_dest_tag, io_cdb.mult_rob_idx};
    assign w_in_data[2] = {io_cdb.memory_result, io_cdb.memory_dest_tag, io_cdb.memory_rob_idx};

    // occupancy flags; a full buffer refuses even if its head leaves this cycle
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            w_ne[s]   = r_count[s] != '0;
            w_full[s] = r_count[s] == CW'(BUF_DEPTH);
            w_enq[s]  = w_in_valid[s] && !w_full[s];
        end
    end

    // grant the first two non-empty heads in rotating order starting at r_ptr
    always_comb begin
        w_g1_valid = 1'b0;
        w_g2_valid = 1'b0;
        w_g1       = 2'd0;
        w_g2       = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (w_ne[rr(r_ptr, k)] && !w_g1_valid) begin
                w_g1_valid = 1'b1;
                w_g1       = rr(r_ptr, k);
            end else if (w_ne[rr(r_ptr, k)] && !w_g2_valid) begin
                w_g2_valid = 1'b1;
                w_g2       = rr(r_ptr, k);
            end
        end
        for (int s = 0; s < 3; s++)
            w_deq[s] = (w_g1_valid && w_g1 == 2'(s)) || (w_g2_valid && w_g2 == 2'(s));
        w_last = w_g2_valid ? w_g2 : w_g1;
    end

    assign w_v1 = w_g1_valid && !i_reset;
    assign w_v2 = w_g2_valid && !i_reset;

    assign io_cdb.cdb1_valid = w_v1;
    assign io_cdb.cdb2_valid = w_v2;
    assign {io_cdb.cdb1_value, io_cdb.cdb1_tag, io_cdb.cdb1_rob_idx} = w_v1 ? r_mem[w_g1][0] : '0;
    assign {io_cdb.cdb2_value, io_cdb.cdb2_tag, io_cdb.cdb2_rob_idx} = w_v2 ? r_mem[w_g2][0] : '0;

    assign io_cdb.adder_available  = !w_full[0] && !i_reset;
    assign io_cdb.mult_available   = !w_full[1] && !i_reset;
    assign io_cdb.memory_available = !w_full[2] && !i_reset;
    assign io_cdb.overflow_err     = r_overflow;

    // shift-register buffers: slot 0 is the head, a dequeue shifts the rest down one slot
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int s = 0; s < 3; s++)
                r_count[s] <= '0;
            r_ptr      <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            for (int s = 0; s < 3; s++) begin
                for (int j = 0; j < BUF_DEPTH; j++) begin
                    if (w_enq[s] && j == int'(r_count[s]) - (w_deq[s] ? 1 : 0))
                        r_mem[s][j] <= w_in_data[s];
                    else if (w_deq[s])
                        r_mem[s][j] <= r_mem[s][(j + 1 < BUF_DEPTH) ? j + 1 : j];
                end
                r_count[s] <= r_count[s] + CW'(w_enq[s]) - CW'(w_deq[s]);
            end
            if (w_g1_valid)
                r_ptr <= (w_last == 2'd2) ? 2'd0 : w_last + 2'd1;
            if ((w_in_valid & w_full) != 3'b000)
                r_overflow <= 1'b1;
        end
    end
endmodule
